// File: rtl/seg7_mux_scan.sv
// Multiplexed common-anode 7-segment scanner: CPU display register, channel select with
// once-per-frame snapshot, hex/raw decode, leading-zero blanking, decimal points and blinking.
module seg7_mux_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_CH       = 8,
  parameter int CTRL_W       = 3,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   we,
  input  logic [3:0]             wmask,
  input  logic [31:0]            wdata,
  input  logic [CTRL_W-1:0]      ctrl,
  input  logic [NUM_CH*32-1:0]   ch_data,
  input  logic                   raw_mode,
  input  logic                   lz_blank,
  input  logic [NUM_DIGITS-1:0]  dp,
  input  logic                   blink_en,
  output logic [31:0]            cpu_reg,
  output logic [7:0]             o_seg,
  output logic [NUM_DIGITS-1:0]  o_sel
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

  logic [31:0]           cpu_reg_q, cpu_reg_d;
  logic [31:0]           snap_q, snap_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_on_q, blink_on_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic        tick, frame_start;
  logic [31:0] chan_sel;
  logic        tail_zero, dp_n;
  logic [6:0]  hex_seg, raw_seg;

  // Channel 0 of ch_data is superseded by the CPU register.
  logic unused_ch0;
  assign unused_ch0 = ^ch_data[31:0];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    cpu_reg_d = cpu_reg_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) cpu_reg_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end

    tick        = (presc_q == PRESC_MAX);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    frame_start = tick && (idx_q == IDX_MAX);

    // Out-of-range selects fall through to zero; channel 0 uses the pre-write register.
    chan_sel = '0;
    if (ctrl == '0) chan_sel = cpu_reg_q;
    for (int k = 1; k < NUM_CH; k++) begin
      if (ctrl == CTRL_W'(k)) chan_sel = ch_data[32*k +: 32];
    end

    snap_d      = snap_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start) begin
      snap_d = chan_sel;
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Walk from the top digit down so tail_zero covers nibbles i..NUM_DIGITS-1.
    tail_zero = 1'b1;
    dp_n      = 1'b1;
    hex_seg   = 7'h7F;
    raw_seg   = 7'h7F;
    sel_d     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero && (snap_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        sel_d[i] = 1'b0;
        dp_n     = ~dp[i];
        hex_seg  = (lz_blank && (i > 0) && tail_zero) ? 7'h7F : hex7(snap_q[4*i +: 4]);
        if (i < 4) raw_seg = ~snap_q[8*(i%4) +: 7];
      end
    end

    seg_d = {dp_n, raw_mode ? raw_seg : hex_seg};
    if (blink_en && !blink_on_q) seg_d = 8'hFF;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_reg_q   <= '0;
      snap_q      <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= 8'hFF;
      sel_q       <= '1;
    end else begin
      cpu_reg_q   <= cpu_reg_d;
      snap_q      <= snap_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign cpu_reg = cpu_reg_q;
  assign o_seg   = seg_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_seg7_mux_scan.sv
// Directed bench for seg7_mux_scan with a fast scan (4 cycles/digit, 2 frames/blink half-period).
module tb_seg7_mux_scan;

  localparam int ND  = 8;
  localparam int NCH = 8;
  localparam int CW  = 3;
  localparam int WAIT_LIMIT = 400;

  logic              clk = 1'b0;
  logic              rstn;
  logic              we;
  logic [3:0]        wmask;
  logic [31:0]       wdata;
  logic [CW-1:0]     ctrl;
  logic [NCH*32-1:0] ch_data;
  logic              raw_mode;
  logic              lz_blank;
  logic [ND-1:0]     dp;
  logic              blink_en;
  logic [31:0]       cpu_reg;
  logic [7:0]        o_seg;
  logic [ND-1:0]     o_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_mux_scan #(
    .NUM_DIGITS(ND), .NUM_CH(NCH), .CTRL_W(CW), .SCAN_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rstn(rstn), .we(we), .wmask(wmask), .wdata(wdata), .ctrl(ctrl),
    .ch_data(ch_data), .raw_mode(raw_mode), .lz_blank(lz_blank), .dp(dp),
    .blink_en(blink_en), .cpu_reg(cpu_reg), .o_seg(o_seg), .o_sel(o_sel)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [ND-1:0] sel_of(input int d);
    logic [ND-1:0] one;
    one = 1;
    return ~(one << d);
  endfunction

  // Advance (on falling edges) until digit d is being driven.
  task automatic wait_sel(input int d);
    int n;
    n = 0;
    while (o_sel !== sel_of(d) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) check_val($sformatf("wait_sel%0d", d), {24'h0, o_sel}, {24'h0, sel_of(d)});
  endtask

  // Land on digit 0 of a frame whose start came after the call.
  task automatic next_frame;
    wait_sel(1);
    wait_sel(0);
  endtask

  task automatic check_digit(input string tag, input int d, input logic [7:0] exp);
    wait_sel(d);
    check_val($sformatf("%s_d%0d", tag, d), {24'h0, o_seg}, {24'h0, exp});
  endtask

  logic [7:0] exp_ch3 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  initial begin
    int n;
    rstn = 1'b0; we = 1'b0; wmask = '0; wdata = '0; ctrl = '0; ch_data = '0;
    raw_mode = 1'b0; lz_blank = 1'b0; dp = '0; blink_en = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_cpu_reg", cpu_reg, 32'h0);
    check_val("rst_seg", {24'h0, o_seg}, 32'hFF);
    check_val("rst_sel", {24'h0, o_sel}, 32'hFF);
    rstn = 1'b1;
    @(negedge clk);
    check_val("post_rst_sel", {24'h0, o_sel}, 32'hFE);
    check_val("post_rst_seg", {24'h0, o_seg}, 32'hC0);

    // Asynchronous reset in the middle of a scan.
    repeat (10) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_val("async_rst_seg", {24'h0, o_seg}, 32'hFF);
    check_val("async_rst_sel", {24'h0, o_sel}, 32'hFF);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_val("rerelease_sel", {24'h0, o_sel}, 32'hFE);

    // Byte-masked CPU writes.
    we = 1'b1; wmask = 4'b0101; wdata = 32'hAABBCCDD;
    @(negedge clk);
    we = 1'b0;
    check_val("cpu_wr_0101", cpu_reg, 32'h00BB00DD);
    we = 1'b1; wmask = 4'b0000; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    we = 1'b0;
    check_val("cpu_wr_0000", cpu_reg, 32'h00BB00DD);
    we = 1'b1; wmask = 4'b1000; wdata = 32'h12345678;
    @(negedge clk);
    we = 1'b0;
    check_val("cpu_wr_1000", cpu_reg, 32'h12BB00DD);

    ctrl = 3'd0;
    next_frame();
    check_digit("cpu", 0, 8'hA1);
    check_digit("cpu", 4, 8'h83);
    check_digit("cpu", 7, 8'hF9);

    // Channel 3 hex decode across all digits.
    ch_data[3*32 +: 32] = 32'h12345678;
    ctrl = 3'd3;
    next_frame();
    for (int d = 0; d < ND; d++) check_digit("ch3", d, exp_ch3[d]);
    next_frame();
    n = 0;
    while (o_sel === 8'hFE && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("slot_len", n, 32'd4);

    // Leading-zero blanking.
    ch_data[5*32 +: 32] = 32'h00000042;
    ctrl = 3'd5; lz_blank = 1'b1;
    next_frame();
    check_digit("lz42", 0, 8'hA4);
    check_digit("lz42", 1, 8'h99);
    check_digit("lz42", 2, 8'hFF);
    check_digit("lz42", 7, 8'hFF);
    ch_data[5*32 +: 32] = 32'h00000000;
    next_frame();
    check_digit("lz0", 0, 8'hC0);
    check_digit("lz0", 1, 8'hFF);
    check_digit("lz0", 7, 8'hFF);
    ch_data[5*32 +: 32] = 32'h00000402;
    next_frame();
    check_digit("lz402", 1, 8'hC0);
    check_digit("lz402", 2, 8'h99);
    check_digit("lz402", 3, 8'hFF);

    // Raw segment mode with decimal point.
    lz_blank = 1'b0; raw_mode = 1'b1; dp = 8'h01;
    ch_data[4*32 +: 32] = 32'h55000180;
    ctrl = 3'd4;
    next_frame();
    check_digit("raw", 0, 8'h7F);
    check_digit("raw", 1, 8'hFE);
    check_digit("raw", 2, 8'hFF);
    check_digit("raw", 3, 8'hAA);
    check_digit("raw", 4, 8'hFF);
    check_digit("raw", 7, 8'hFF);

    // Decimal point in hex mode.
    raw_mode = 1'b0; dp = 8'h80; ctrl = 3'd3;
    next_frame();
    check_digit("hexdp", 6, 8'hA4);
    check_digit("hexdp", 7, 8'h79);

    // Channel change mid-frame takes effect only at the next frame start.
    dp = '0;
    ch_data[7*32 +: 32] = 32'h9ABCDEF0;
    next_frame();
    wait_sel(3);
    ctrl = 3'd7;
    check_digit("midold", 4, 8'h99);
    check_digit("midold", 7, 8'hF9);
    check_digit("midnew", 0, 8'hC0);
    check_digit("midnew", 7, 8'h90);

    // Blink: restart from reset so the phase is known.
    rstn = 1'b0;
    @(negedge clk);
    ctrl = 3'd3; blink_en = 1'b1;
    rstn = 1'b1;
    next_frame(); check_digit("blink_f1", 0, 8'h80);
    next_frame(); check_digit("blink_f2", 0, 8'hFF);
    check_val("blink_f2_sel", {24'h0, o_sel}, 32'hFE);
    next_frame(); check_digit("blink_f3", 0, 8'hFF);
    next_frame(); check_digit("blink_f4", 0, 8'h80);
    next_frame(); check_digit("blink_f5", 0, 8'h80);
    blink_en = 1'b0;
    next_frame(); check_digit("blink_off_f6", 0, 8'h80);
    blink_en = 1'b1;
    next_frame(); check_digit("blink_f7", 0, 8'hFF);
    next_frame(); check_digit("blink_f8", 0, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
